uart_receiver: RTL
==================

Name: uart_receiver

Overview:
- 8-bit UART receiver, counterpart of the peripheral unit's UART transmitter.
- Frame format: 1 start bit (low), 8 data bits LSB first, 1 stop bit (high); idle line high.
- Runs on the system clock and oversamples rx by CLKS_PER_BIT per bit.
- Presents each received byte with a one-cycle done pulse; flags bad stop bits with frame_err.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit; legal values are even and >= 4.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  receive enable; sampled only in IDLE
rx  input  1  serial line, asynchronous to clk
out  output  8  last correctly received byte; holds its value until the next good frame
done  output  1  one-cycle pulse when out is updated
busy  output  1  high while a frame is in progress
frame_err  output  1  one-cycle pulse when the stop bit is sampled low

Behaviour:
- Reset (async, active-high): state=IDLE; out=8'h00; done=0; busy=0; frame_err=0; both synchronizer flops=1; bit counter and sample counter=0.
- rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s only.
- Sample counter width is $clog2(CLKS_PER_BIT). Bit index is 3 bits.
- done and frame_err default to 0 every cycle and are never high together.
- IDLE: busy=0. If en=1 and rx_s=0, go to START and clear the sample counter. If en=0, the line is ignored.
- START: busy=1. Count to CLKS_PER_BIT/2-1 (mid start bit), then sample:
  - rx_s=1: glitch; return to IDLE, no pulse.
  - rx_s=0: go to DATA; clear counter and bit index.
- DATA: count to CLKS_PER_BIT-1, then sample rx_s into shift[7], shifting right.
  - The first sampled bit ends up in bit 0.
  - After bit index 7 (wrap 7->0), go to STOP.
- STOP: count to CLKS_PER_BIT-1, then sample:
  - rx_s=1: out<=shift, done=1 for one cycle, go to IDLE.
  - rx_s=0: frame_err=1 for one cycle, out unchanged, go to BREAK.
- BREAK: busy=1. Wait until rx_s=1, then go to IDLE. A held-low line (break) therefore produces exactly one frame_err and no further frames.
- An illegal state encoding goes to IDLE on the next clock.
- en falling mid-frame does not abort the frame.
- A frame can begin in the first cycle after returning to IDLE, so back-to-back frames with one stop bit are received.
- Latency: done or frame_err asserts between 9.5*CLKS_PER_BIT and 9.5*CLKS_PER_BIT+4 clk cycles after the rx falling edge of the start bit.
- Reset asserted mid-frame aborts immediately: no done, and out keeps its reset value of 8'h00.

Test Plan:
- CLKS_PER_BIT=16, en=1, send 8'hA5 with stop=1 -> out=8'hA5, a single done pulse in window [152,156] cycles after the start edge, frame_err never high, busy high throughout the frame.
- Send 8'h3C followed immediately by 8'hC3 (no idle gap) -> two done pulses, out=8'h3C then 8'hC3.
- rx low pulse of 4 cycles while idle -> returns to IDLE, no done or frame_err, busy low again within 12 cycles.
- Send 8'h55 with stop=0, then hold rx low 40 cycles, then high -> exactly one frame_err, out keeps its previous value, busy drops only after rx returns high, and the next frame 8'h0F is received correctly.
- en=0 while sending 8'hFF -> no busy, done or out change; en=1 then send 8'h81 -> out=8'h81.
- Assert rst during data bit 4 of 8'h12 -> out=8'h00, busy=0 asynchronously; after release, a fresh 8'h12 is received correctly.

Source files
------------

// File: rtl/uart_receiver.sv
// 8-bit UART receiver (8N1, LSB first) oversampled by CLKS_PER_BIT system clocks per bit.
// Emits the received byte with a one-cycle done pulse and flags a low stop bit with frame_err.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       rx,
    output logic [7:0] out,
    output logic       done,
    output logic       busy,
    output logic       frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic [2:0]    state_q, state_d;
    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    out_q, out_d;
    logic          done_q, done_d;
    logic          ferr_q, ferr_d;
    logic          rx_s;

    assign rx_s = sync2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        out_d   = out_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en && !rx_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                // Mid start bit: a line that has gone high again was only a glitch.
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        bit_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        out_d   = shift_q;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            // A held-low line is reported once, then ignored until it returns high.
            S_BREAK: begin
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            out_q   <= 8'h00;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= rx;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            out_q   <= out_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign out       = out_q;
    assign done      = done_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q == S_START) || (state_q == S_DATA) ||
                       (state_q == S_STOP)  || (state_q == S_BREAK);
endmodule
